// File: rtl/instr_mem_loadable.sv
// instr_mem_loadable: run-time loadable instruction memory.
// A program is streamed in over a valid/ready load port (EMPTY -> LOADING -> READY).
// The fetch stage then reads it with a request/ready handshake and a 1-cycle latency.
// Fetches at or beyond the loaded word count return NOP_INSTR and raise fetch_fault.

module instr_mem_loadable #(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 32,
  parameter int                DEPTH     = 32,
  parameter logic [DATA_W-1:0] NOP_INSTR = 32'h48000000,
  parameter int                CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instruction,
  output logic              fetch_fault,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              loaded,
  output logic [CNT_W-1:0]  load_count
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    EMPTY,
    LOADING,
    READY
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                loaded_q, loaded_d;
  logic                instr_valid_q, instr_valid_d;
  logic                fetch_fault_q, fetch_fault_d;
  logic [DATA_W-1:0]   instruction_q, instruction_d;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                load_fire;
  logic                fetch_fire;
  logic                fetch_in_range;
  logic                last_word;
  logic [ADDR_W-1:0]   count_ext;
  logic [IDX_W-1:0]    wr_idx;
  logic [IDX_W-1:0]    rd_idx;

  // load_start always wins: it blocks both the load port and the fetch port for that cycle
  assign load_ready  = (state_q == LOADING) && !load_start;
  assign fetch_ready = (state_q == READY) && !load_start;

  assign load_fire  = load_valid && load_ready;
  assign fetch_fire = fetch_req && fetch_ready;

  // full-width range check so high PC bits can never alias into the array
  assign count_ext      = ADDR_W'(count_q);
  assign fetch_in_range = fetch_addr < count_ext;

  // the DEPTH-th word closes the program even without load_last, so the pointer never overflows
  assign last_word = load_last || (ptr_q == CNT_W'(DEPTH - 1));

  assign wr_idx = ptr_q[IDX_W-1:0];
  assign rd_idx = fetch_addr[IDX_W-1:0];

  assign instr_valid = instr_valid_q;
  assign instruction = instruction_q;
  assign fetch_fault = fetch_fault_q;
  assign loaded      = loaded_q;
  assign load_count  = count_q;

  // next-state logic for the load FSM and the registered fetch response
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    count_d       = count_q;
    loaded_d      = loaded_q;
    instr_valid_d = 1'b0;
    fetch_fault_d = 1'b0;
    instruction_d = instruction_q;

    if (load_start) begin
      state_d  = LOADING;
      ptr_d    = '0;
      count_d  = '0;
      loaded_d = 1'b0;
    end else if (load_fire) begin
      ptr_d   = ptr_q + CNT_W'(1);
      count_d = ptr_q + CNT_W'(1);
      if (last_word) begin
        state_d  = READY;
        loaded_d = 1'b1;
      end
    end

    if (fetch_fire) begin
      instr_valid_d = 1'b1;
      if (fetch_in_range) begin
        instruction_d = mem[rd_idx];
        fetch_fault_d = 1'b0;
      end else begin
        instruction_d = NOP_INSTR;
        fetch_fault_d = 1'b1;
      end
    end
  end

  // FSM and output registers; reset discards any partial program immediately
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= EMPTY;
      ptr_q         <= '0;
      count_q       <= '0;
      loaded_q      <= 1'b0;
      instr_valid_q <= 1'b0;
      fetch_fault_q <= 1'b0;
      instruction_q <= NOP_INSTR;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      count_q       <= count_d;
      loaded_q      <= loaded_d;
      instr_valid_q <= instr_valid_d;
      fetch_fault_q <= fetch_fault_d;
      instruction_q <= instruction_d;
    end
  end

  // program storage is never cleared; only words handshaken in LOADING are written
  always_ff @(posedge clock) begin
    if (load_fire) begin
      mem[wr_idx] <= load_data;
    end
  end

endmodule

// File: tb/tb_instr_mem_loadable.sv
// tb_instr_mem_loadable: self-checking bench for instr_mem_loadable.
// A behavioural model of the load FSM predicts handshake outputs each cycle,
// and accepted fetches push their expected word into a scoreboard queue.

module tb_instr_mem_loadable;

  localparam logic [31:0] NOP = 32'h48000000;

  logic        clock = 1'b0;
  logic        reset;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_ready;
  logic        instr_valid;
  logic [31:0] instruction;
  logic        fetch_fault;
  logic        load_start;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_last;
  logic        load_ready;
  logic        loaded;
  logic [5:0]  load_count;

  instr_mem_loadable dut (
    .clock       (clock),
    .reset       (reset),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_ready (fetch_ready),
    .instr_valid (instr_valid),
    .instruction (instruction),
    .fetch_fault (fetch_fault),
    .load_start  (load_start),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_last   (load_last),
    .load_ready  (load_ready),
    .loaded      (loaded),
    .load_count  (load_count)
  );

  // free-running 10-unit clock
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] data;
    logic        fault;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] exp_instr;
    logic        exp_fault;
  } vec_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;

  // behavioural model: 0=EMPTY 1=LOADING 2=READY
  int          m_state;
  logic [31:0] m_mem [32];
  int          m_ptr;
  int          m_count;
  logic        m_loaded;
  logic [31:0] m_instr;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    m_state  = 0;
    m_ptr    = 0;
    m_count  = 0;
    m_loaded = 1'b0;
    m_instr  = NOP;
    sb.delete();
  endtask

  // drive one cycle of inputs, check combinational handshakes, advance model, check registered outputs
  task automatic applyStimulus(input logic fr, input logic [31:0] fa, input logic ls, input logic lv,
                               input logic [31:0] ld, input logic ll,
                               input logic use_exp, input logic [31:0] exp_instr, input logic exp_fault);
    logic exp_fready;
    logic exp_lready;
    exp_t e;
    @(negedge clock);
    fetch_req  = fr;
    fetch_addr = fa;
    load_start = ls;
    load_valid = lv;
    load_data  = ld;
    load_last  = ll;
    #1;
    exp_fready = (m_state == 2) && !ls;
    exp_lready = (m_state == 1) && !ls;
    checkOutput("fetch_ready", {31'd0, fetch_ready}, {31'd0, exp_fready});
    checkOutput("load_ready", {31'd0, load_ready}, {31'd0, exp_lready});

    if (fr && exp_fready) begin
      if (use_exp) begin
        e.data  = exp_instr;
        e.fault = exp_fault;
      end else if (fa < 32'(m_count)) begin
        e.data  = m_mem[fa[4:0]];
        e.fault = 1'b0;
      end else begin
        e.data  = NOP;
        e.fault = 1'b1;
      end
      sb.push_back(e);
      m_instr = e.data;
    end

    if (ls) begin
      m_state  = 1;
      m_ptr    = 0;
      m_count  = 0;
      m_loaded = 1'b0;
    end else if (lv && exp_lready) begin
      m_mem[m_ptr] = ld;
      m_count      = m_ptr + 1;
      if (ll || m_ptr == 31) begin
        m_state  = 2;
        m_loaded = 1'b1;
      end
      m_ptr = m_ptr + 1;
    end

    @(posedge clock);
    #1;
    if (instr_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL instr_valid actual=1 expected=0 (no fetch accepted)");
      end else begin
        e = sb.pop_front();
        checkOutput("instruction", instruction, e.data);
        checkOutput("fetch_fault", {31'd0, fetch_fault}, {31'd0, e.fault});
      end
    end else begin
      if (sb.size() != 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL instr_valid actual=%b expected=1", instr_valid);
        void'(sb.pop_front());
      end else begin
        checkOutput("fetch_fault_idle", {31'd0, fetch_fault}, 32'd0);
        checkOutput("instruction_hold", instruction, m_instr);
      end
    end
    checkOutput("loaded", {31'd0, loaded}, {31'd0, m_loaded});
    checkOutput("load_count", {26'd0, load_count}, 32'(m_count));
  endtask

  task automatic idle();
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic startLoad();
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic loadWord(input logic [31:0] d, input logic last);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, d, last, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic fetchWord(input logic [31:0] a);
    applyStimulus(1'b1, a, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_loaded"}, {31'd0, loaded}, 32'd0);
    checkOutput({tag, "_load_count"}, {26'd0, load_count}, 32'd0);
    checkOutput({tag, "_instr_valid"}, {31'd0, instr_valid}, 32'd0);
    checkOutput({tag, "_fetch_fault"}, {31'd0, fetch_fault}, 32'd0);
    checkOutput({tag, "_instruction"}, instruction, NOP);
  endtask

  task automatic doReset();
    @(negedge clock);
    reset      = 1'b1;
    fetch_req  = 1'b0;
    fetch_addr = '0;
    load_start = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    load_last  = 1'b0;
    #1;
    checkResetValues("reset");
    modelReset();
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    vec_t tbl [7];
    logic [31:0] d;
    logic        v;

    reset      = 1'b0;
    fetch_req  = 1'b0;
    fetch_addr = '0;
    load_start = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    load_last  = 1'b0;
    modelReset();

    for (int i = 0; i < 5; i++) begin
      tbl[i].addr      = 32'(i);
      tbl[i].exp_instr = 32'h30010001 + 32'(i);
      tbl[i].exp_fault = 1'b0;
    end
    tbl[5].addr = 32'd5;         tbl[5].exp_instr = NOP; tbl[5].exp_fault = 1'b1;
    tbl[6].addr = 32'hFFFF0000;  tbl[6].exp_instr = NOP; tbl[6].exp_fault = 1'b1;

    // reset state, then a fetch with nothing loaded is refused
    doReset();
    fetchWord(32'd0);
    idle();

    // five-word program, back-to-back fetches in and out of range
    startLoad();
    for (int i = 0; i < 5; i++) loadWord(32'h30010001 + 32'(i), (i == 4));
    for (int i = 0; i < 7; i++)
      applyStimulus(1'b1, tbl[i].addr, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, tbl[i].exp_instr, tbl[i].exp_fault);
    idle();

    // full-depth program without load_last closes itself on the 32nd word
    startLoad();
    for (int i = 0; i < 32; i++) loadWord(32'hA0000000 + 32'(i), 1'b0);
    loadWord(32'hDEADBEEF, 1'b0);
    applyStimulus(1'b1, 32'd31, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'hA000001F, 1'b0);
    fetchWord(32'd32);
    fetchWord(32'd0);
    idle();

    // gappy stream with a restart in the middle
    startLoad();
    for (int i = 0; i < 20; i++) begin
      d = $urandom;
      v = 1'($urandom_range(0, 1));
      if (i == 8)
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, d, 1'b0, 1'b0, 32'd0, 1'b0);
      else
        applyStimulus(1'b0, 32'd0, 1'b0, v, d, 1'b0, 1'b0, 32'd0, 1'b0);
    end
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'h11111111, 1'b1, 1'b0, 32'd0, 1'b0);
    loadWord(32'h5A5A0001, 1'b1);
    for (int a = 0; a <= m_count; a++) fetchWord(32'(a));
    idle();

    // reset in the middle of a load discards the partial program
    startLoad();
    for (int i = 0; i < 3; i++) loadWord(32'hC0000000 + 32'(i), 1'b0);
    @(negedge clock);
    load_valid = 1'b1;
    load_data  = 32'hC0000003;
    #2;
    reset = 1'b1;
    #1;
    checkResetValues("midload_reset");
    modelReset();
    @(negedge clock);
    reset = 1'b0;
    fetchWord(32'd0);
    loadWord(32'hC0000009, 1'b1);

    // load_start beats a same-cycle fetch in READY
    startLoad();
    loadWord(32'h77770000, 1'b0);
    loadWord(32'h77770001, 1'b1);
    fetchWord(32'd1);
    applyStimulus(1'b1, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    fetchWord(32'd0);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
